// File: rtl/ff_pipe_pkg.sv
// Shared constants and helpers for counted register pipes.
// The count width is derived once here so every counted pipe sizes it identically.
package ff_pipe_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

  // Wide enough to hold every occupancy from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_pipe_if.sv
// Valid/ready bus around a register pipe: producer side, consumer side and the occupancy count.
interface ff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CW    = ff_pipe_pkg::count_width(3)
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );

endinterface

// File: rtl/ff_pipe_stage.sv
// One pipe stage: a valid bit plus a data word, cleared by reset or flush.
// Data only moves when the upstream word is valid, so bubbles never overwrite held data.
module ff_pipe_stage
  import ff_pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else if (en) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/ff_pipe.sv
// Chain of DEPTH valid/data stages with valid/ready backpressure, sync flush and a registered count.
module ff_pipe
  import ff_pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  ff_pipe_if.slave  bus
);

  localparam int CW = count_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   r;
  logic [CW-1:0]    count;
  logic             in_xfer;
  logic             out_xfer;

  // A stage can advance when it is empty or everything downstream of it can advance.
  always_comb begin
    r        = '0;
    r[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = ~v[i] | r[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      ff_pipe_stage #(
        .WIDTH    (WIDTH),
        .RST_DATA (RST_DATA)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .en       (r[i]),
        .up_valid (bus.in_valid),
        .up_data  (bus.in_data),
        .valid    (v[i]),
        .data     (d[i])
      );
    end else begin : g_rest
      ff_pipe_stage #(
        .WIDTH    (WIDTH),
        .RST_DATA (RST_DATA)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .en       (r[i]),
        .up_valid (v[i-1]),
        .up_data  (d[i-1]),
        .valid    (v[i]),
        .data     (d[i])
      );
    end
  end

  assign bus.in_ready  = r[0] & ~clr;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = count;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  // A flush discards everything, including a word the consumer takes that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule
